mem_arbiter: RTL

- Two-master to one-slave arbiter between the I-cache and D-cache memory ports and the single off-chip memory.
- Each cache port uses the cache memory protocol: mem_read/mem_write held until a one-cycle mem_ready, with 28-bit block address and 128-bit block data.
- Requests are registered, one transaction is in flight at a time, and simultaneous requests get round-robin fairness.

---
 rtl/mem_pkg.sv | 35 +++
 rtl/mem_arbiter_if.sv | 16 +
 rtl/mem_arbiter_rr_arb2.sv | 46 ++++
 rtl/mem_arbiter.sv | 93 +++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared widths, encodings and request payload for the I/D memory arbiter.
package mem_pkg;

  localparam int unsigned ADDR_W = 28;
  localparam int unsigned DATA_W = 128;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Latched request: op (1 = write), block address and write block.
  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  // Pack one port's request; write wins when read and write are both high.
  function automatic mem_req_t make_req(input logic              wr,
                                        input logic [ADDR_W-1:0] addr,
                                        input logic [DATA_W-1:0] wdata);
    mem_req_t r;
    r.wr    = wr;
    r.addr  = addr;
    r.wdata = wdata;
    return r;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache memory-port bundle: strobes held until a one-cycle ready pulse.
interface mem_arbiter_if;
  import mem_pkg::*;

  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic [DATA_W-1:0] rdata;

  // Requester side (cache, or the arbiter facing memory).
  modport master (output read, write, addr, wdata, input ready, rdata);
  // Responder side (the arbiter facing a cache, or memory).
  modport slave  (input read, write, addr, wdata, output ready, rdata);
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant; the last-served port loses a tie.
module rr_arb2
  import mem_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   req_i,
  input  logic   req_d,
  input  logic   upd,
  input  owner_e upd_owner,
  output logic   gnt_c,
  output owner_e gnt_owner_c
);

  owner_e last_q;
  owner_e last_d;

  // Remember who was served when a transaction completes.
  always_comb begin
    last_d = last_q;
    if (upd) begin
      last_d = upd_owner;
    end
  end

  // Last-grant register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= OWN_I;
    end else begin
      last_q <= last_d;
    end
  end

  // Single requester wins outright; on a tie the port not served last wins.
  always_comb begin
    gnt_c       = req_i | req_d;
    gnt_owner_c = OWN_I;
    if (req_i && req_d) begin
      gnt_owner_c = (last_q == OWN_I) ? OWN_D : OWN_I;
    end else if (req_d) begin
      gnt_owner_c = OWN_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// I-cache / D-cache to single off-chip memory arbiter, one transaction in flight.
module mem_arbiter
  import mem_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  i_port,
  mem_arbiter_if.slave  d_port,
  mem_arbiter_if.master mem_port
);

  state_e   state_q;
  state_e   state_d;
  owner_e   owner_q;
  owner_e   owner_d;
  mem_req_t lat_q;
  mem_req_t lat_d;

  logic     i_req;
  logic     d_req;
  mem_req_t i_pl;
  mem_req_t d_pl;
  logic     gnt_c;
  owner_e   gnt_owner_c;
  logic     busy_c;
  logic     done_c;

  assign i_req  = i_port.read | i_port.write;
  assign d_req  = d_port.read | d_port.write;
  assign i_pl   = make_req(i_port.write, i_port.addr, i_port.wdata);
  assign d_pl   = make_req(d_port.write, d_port.addr, d_port.wdata);
  assign busy_c = (state_q == BUSY);
  assign done_c = busy_c & mem_port.ready;

  rr_arb2 u_rr (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (i_req),
    .req_d       (d_req),
    .upd         (done_c),
    .upd_owner   (owner_q),
    .gnt_c       (gnt_c),
    .gnt_owner_c (gnt_owner_c)
  );

  // Grant and latch in IDLE; wait for the memory ready pulse in BUSY.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    lat_d   = lat_q;
    case (state_q)
      IDLE: begin
        if (gnt_c) begin
          state_d = BUSY;
          owner_d = gnt_owner_c;
          lat_d   = (gnt_owner_c == OWN_D) ? d_pl : i_pl;
        end
      end
      BUSY: begin
        if (mem_port.ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, owner and latched request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= OWN_I;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      lat_q   <= lat_d;
    end
  end

  // Memory side: strobes drop in the ready cycle, address/data held from the latch.
  assign mem_port.read  = busy_c & ~lat_q.wr & ~mem_port.ready;
  assign mem_port.write = busy_c &  lat_q.wr & ~mem_port.ready;
  assign mem_port.addr  = lat_q.addr;
  assign mem_port.wdata = lat_q.wdata;

  // Cache side: ready only to the owner, read data broadcast.
  assign i_port.ready = done_c & (owner_q == OWN_I);
  assign d_port.ready = done_c & (owner_q == OWN_D);
  assign i_port.rdata = mem_port.rdata;
  assign d_port.rdata = mem_port.rdata;

endmodule
